// File: rtl/bit_serial_adder_if.sv
// Start/done handshake bundle for the bit-serial adder.
// The controller drives the master side and the adder is the slave.
interface bit_serial_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;

  modport master (
    output start, A, B, Cin,
    input  busy, done, S, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, S, Cout
  );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: {Cout,S} = A + B + Cin, one bit per clock, LSB first.
// A single full-adder cell walks the latched operands; the result is published on the done edge.
module bit_serial_adder #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  bit_serial_adder_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d, s_q, s_d;
  logic             carry_q, carry_d, cout_q, cout_d, done_q, done_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sum_bit, carry_nxt, last_bit;

  assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign last_bit  = (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (last_bit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state; start is only looked at in idle, so a start while busy is dropped.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == StIdle) begin
      if (bus.start) begin
        a_d     = bus.A;
        b_d     = bus.B;
        carry_d = bus.Cin;
        res_d   = '0;
        cnt_d   = '0;
      end
    end else begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      carry_d = carry_nxt;
      res_d   = {sum_bit, res_q[WIDTH-1:1]};
      cnt_d   = cnt_q + 1'b1;
      if (last_bit) begin
        s_d    = {sum_bit, res_q[WIDTH-1:1]};
        cout_d = carry_nxt;
        done_d = 1'b1;
      end
    end
  end

  always_comb begin
    bus.busy = (state_q == StRun);
    bus.done = done_q;
    bus.S    = s_q;
    bus.Cout = cout_q;
  end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed vector table, handshake corner cases,
// and randomized back-to-back operations against a plain-arithmetic reference.
module tb_bit_serial_adder;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bit_serial_adder_if #(.WIDTH(W)) bus ();

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One operation with the bench as controller; operands are scrambled right after the start edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        output logic [W:0] res, output int lat, output int busy_n,
                        output bit held);
    logic [W:0] prev;
    prev = {bus.Cout, bus.S};
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    bus.Cin   = 1'($urandom);
    busy_n    = bus.busy ? 1 : 0;
    held      = ({bus.Cout, bus.S} === prev);
    lat       = 0;
    res       = 'x;
    while (lat < W + 4) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) begin
        res = {bus.Cout, bus.S};
        break;
      end
      if (bus.busy) busy_n++;
      if ({bus.Cout, bus.S} !== prev) held = 1'b0;
    end
  endtask

  initial begin
    logic [W:0]   res, expv;
    logic [W-1:0] ra, rb;
    logic         rc;
    int           lat, busy_n, seen;
    bit           held;

    vecs[0] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0};
    vecs[6] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;
    #12;
    check("reset_state", {bus.busy, bus.done, bus.Cout, bus.S}, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, res, lat, busy_n, held);
      check($sformatf("vec%0d_sum", i), res, {vecs[i].cout, vecs[i].s});
      check($sformatf("vec%0d_latency", i), lat, W);
      check($sformatf("vec%0d_busy_cycles", i), busy_n, W);
      check($sformatf("vec%0d_hold", i), held, 1);
    end

    // Start pulse during a run must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 32'd10;
    bus.B     = 32'd20;
    bus.Cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    res = 'x;
    while (lat < W + 4) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 4) begin
        bus.start = 1'b1;
        bus.A     = 32'h1111_1111;
        bus.B     = 32'h2222_2222;
        bus.Cin   = 1'b1;
      end else if (lat == 5) begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        res = {bus.Cout, bus.S};
        break;
      end
    end
    check("ignore_start_sum", res, 33'd30);
    check("ignore_start_latency", lat, W);
    repeat (2) @(posedge clk);
    #1;
    check("ignore_start_no_rerun", {bus.busy, bus.done}, 2'b00);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 32'd7;
    bus.B     = 32'd9;
    bus.Cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_outputs", {bus.busy, bus.done, bus.Cout, bus.S}, '0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (W + 5) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    check("abort_no_done", seen, 0);

    run_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, res, lat, busy_n, held);
    check("recover_sum", res, 33'h0_1010_1011);

    // Back-to-back random operations, next start raised in the done cycle.
    ra = $urandom;
    rb = $urandom;
    rc = 1'($urandom);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = ra;
    bus.B     = rb;
    bus.Cin   = rc;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      expv      = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      bus.A     = $urandom;
      bus.B     = $urandom;
      lat       = 0;
      seen      = 0;
      while (lat < W + 4 && seen == 0) begin
        @(posedge clk);
        #1;
        lat++;
        if (bus.done) seen = 1;
      end
      check($sformatf("rand%0d_sum", i), {bus.Cout, bus.S}, expv);
      check($sformatf("rand%0d_latency", i), lat, W);
      ra        = $urandom;
      rb        = $urandom;
      rc        = 1'($urandom);
      bus.start = 1'b1;
      bus.A     = ra;
      bus.B     = rb;
      bus.Cin   = rc;
    end
    bus.start = 1'b0;
    repeat (W + 4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
